// File: rtl/forward_ctrl_unit.sv
// Operand redirection select + load-use stall for the EX stage; optional FWD_STALL_CNT_EN stall counter.
// Latency: redirection_ctrl registered (valid when instr is in EX); stall is combinational (0 cycles).
// Backpressure: stall holds PC and IF/ID for one cycle and injects a bubble; flush overrides stall.
module forward_ctrl_unit #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [3:0]       redirection_ctrl,
  output logic [31:0]      stall_count
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } ex_slot_t;

  // Load-ness no longer matters once the producer reaches MEM: mem_out is the source either way.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
  } mem_slot_t;

  ex_slot_t  s_ex;
  mem_slot_t s_mem;

  logic       hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
  logic       hazard;
  logic       load_ex;
  logic [1:0] sel_a, sel_b;

  function automatic logic slot_hit(input logic v, input logic we,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] r);
    return v & we & (rd == r) & (r != '0);
  endfunction

  assign hit_ex_rs  = slot_hit(s_ex.valid,  s_ex.we,  s_ex.rd,  id_rs);
  assign hit_ex_rt  = slot_hit(s_ex.valid,  s_ex.we,  s_ex.rd,  id_rt);
  assign hit_mem_rs = slot_hit(s_mem.valid, s_mem.we, s_mem.rd, id_rs);
  assign hit_mem_rt = slot_hit(s_mem.valid, s_mem.we, s_mem.rd, id_rt);

  assign hazard  = id_valid & s_ex.load &
                   ((id_use_rs & hit_ex_rs) | (id_use_rt & hit_ex_rt));
  assign stall   = hazard & ~flush;
  assign load_ex = id_valid & ~stall & ~flush;

  // Nearest producer wins; a load in EX never selects alu_out (it stalls instead).
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (id_use_rs) begin
      if (hit_ex_rs && !s_ex.load) sel_a = 2'b01;
      else if (hit_mem_rs)         sel_a = 2'b10;
    end
    if (id_use_rt) begin
      if (hit_ex_rt && !s_ex.load) sel_b = 2'b01;
      else if (hit_mem_rt)         sel_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ex             <= '0;
      s_mem            <= '0;
      redirection_ctrl <= 4'b0000;
    end else begin
      s_mem.valid <= s_ex.valid;
      s_mem.rd    <= s_ex.rd;
      s_mem.we    <= s_ex.we;
      if (load_ex) begin
        s_ex.valid       <= 1'b1;
        s_ex.rd          <= id_rd;
        s_ex.we          <= id_reg_we;
        s_ex.load        <= id_is_load;
        redirection_ctrl <= {sel_b, sel_a};
      end else begin
        s_ex             <= '0;
        redirection_ctrl <= 4'b0000;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Directed bench for forward_ctrl_unit: expected select words queued at drive time, checked after the edge.
module tb_forward_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, id_reg_we, id_is_load, flush;
  logic        stall;
  logic [3:0]  redirection_ctrl;
  logic [31:0] stall_count;

  int          tests = 0;
  int          fails = 0;
  logic [3:0]  exp_q[$];
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  forward_ctrl_unit #(.REG_W(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_use_rs        (id_use_rs),
    .id_use_rt        (id_use_rt),
    .id_rd            (id_rd),
    .id_reg_we        (id_reg_we),
    .id_is_load       (id_is_load),
    .flush            (flush),
    .stall            (stall),
    .redirection_ctrl (redirection_ctrl),
    .stall_count      (stall_count)
  );

  task automatic step(input logic r, input logic v,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic fl, input logic exp_stall,
                      input logic [3:0] exp_ctrl, input string tag);
    logic [3:0] want;
    @(negedge clk);
    rst = r; id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_reg_we = we; id_is_load = ld; flush = fl;
    #1;
    tests++;
    assert (stall === exp_stall) else begin
      fails++;
      $error("FAIL %s stall: got %b want %b", tag, stall, exp_stall);
    end
    exp_q.push_back(exp_ctrl);
`ifdef FWD_STALL_CNT_EN
    if (exp_stall && !r && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    tests++;
    assert (redirection_ctrl === want) else begin
      fails++;
      $error("FAIL %s ctrl: got %b want %b", tag, redirection_ctrl, want);
    end
    tests++;
    assert (stall_count === exp_cnt) else begin
      fails++;
      $error("FAIL %s stall_count: got %0d want %0d", tag, stall_count, exp_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_reg_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    assert (stall === 1'b0) else begin fails++; $error("FAIL reset stall: got %b want 0", stall); end
    tests++;
    assert (redirection_ctrl === 4'b0000) else begin
      fails++; $error("FAIL reset ctrl: got %b want 0000", redirection_ctrl);
    end
    tests++;
    assert (stall_count === 32'd0) else begin
      fails++; $error("FAIL reset stall_count: got %0d want 0", stall_count);
    end

    //   rst v   rs  urs rt  urt rd  we ld fl  stall ctrl
    // ALU -> ALU on operand A
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 4'b0000, "addu3");
    step(0, 1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0, 0, 4'b0001, "subu_ex_a");
    step(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, "bubble");
    // distance-2 on operand B
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 4'b0000, "addu3_b");
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, "nop");
    step(0, 1, 5'd7, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0, 4'b1000, "or_mem_b");
    // both distances, same register: nearest wins
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 4'b0000, "addu3_c");
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 4'b0000, "addu3_d");
    step(0, 1, 5'd3, 1, 5'd3, 1, 5'd8, 1, 0, 0, 0, 4'b0101, "and_nearest");
    // load-use on A: one stall cycle then mem_out
    step(0, 1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 4'b0000, "lw9");
    step(0, 1, 5'd9, 1, 5'd2, 1, 5'd10, 1, 0, 0, 1, 4'b0000, "lu_stall");
    step(0, 1, 5'd9, 1, 5'd2, 1, 5'd10, 1, 0, 0, 0, 4'b0010, "lu_mem_a");
    // $0 never forwarded
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 4'b0000, "wr_r0");
    step(0, 1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0, 0, 4'b0000, "rd_r0");
    // flush coinciding with a load-use hazard
    step(0, 1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 0, 0, 4'b0000, "lw12");
    step(0, 1, 5'd12, 1, 5'd12, 1, 5'd13, 1, 0, 1, 0, 4'b0000, "flush_haz");
    step(0, 1, 5'd12, 1, 5'd2, 1, 5'd14, 1, 0, 0, 0, 4'b0010, "after_flush");
    // load-use on B
    step(0, 1, 5'd1, 1, 5'd0, 0, 5'd15, 1, 1, 0, 0, 4'b0000, "lw15");
    step(0, 1, 5'd2, 1, 5'd15, 1, 5'd16, 1, 0, 0, 1, 4'b0000, "lu_stall_b");
    step(0, 1, 5'd2, 1, 5'd15, 1, 5'd16, 1, 0, 0, 0, 4'b1000, "lu_mem_b");
    // reset mid-operation drops the pending load
    step(0, 1, 5'd1, 1, 5'd0, 0, 5'd17, 1, 1, 0, 0, 4'b0000, "lw17");
    step(1, 1, 5'd17, 1, 5'd2, 1, 5'd18, 1, 0, 0, 1, 4'b0000, "rst_haz");
    step(0, 1, 5'd17, 1, 5'd2, 1, 5'd18, 1, 0, 0, 0, 4'b0000, "post_rst");
    // use_rs masks a matching rs; rt still forwards
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 4'b0000, "addu5");
    step(0, 1, 5'd5, 0, 5'd5, 1, 5'd19, 1, 0, 0, 0, 4'b0100, "use_mask");
    // non-writer in EX does not forward
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd20, 0, 0, 0, 0, 4'b0000, "nowe20");
    step(0, 1, 5'd20, 1, 5'd20, 1, 5'd21, 1, 0, 0, 0, 4'b0000, "rd_nowe");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
